sap_program_loader: RTL and testbench



---
 rtl/sap_program_loader_pkg.sv | 28 ++
 rtl/sap_program_loader_if.sv | 26 ++
 rtl/sap_program_loader.sv | 118 +++++++++++
 tb/tb_sap_program_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sap_program_loader_pkg.sv
// Shared constants, FSM state type and checksum helper for the SAP byte-stream program loader.
// Imported by the loader interface and the loader itself.
package sap_program_loader_pkg;

    localparam int          DATA_W    = 16;
    localparam int          ADDR_W    = 8;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    // Record is good when the running sum plus the trailing checksum byte wraps to zero.
    function automatic logic sum_ok(input logic [7:0] sum, input logic [7:0] csum);
        logic [7:0] total;
        total = sum + csum;
        return total == 8'h00;
    endfunction

endpackage

// File: rtl/sap_program_loader_if.sv
// Byte-stream input, RAM write port and CPU-hold status bundle of the program loader.
// master = byte source / RAM side, slave = loader.
interface sap_program_loader_if;
    import sap_program_loader_pkg::*;

    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_wdata;
    logic               cpu_hold;
    logic               load_done;
    logic               load_err;

    modport master (
        output in_data, in_valid,
        input  in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, load_done, load_err
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, load_done, load_err
    );

endinterface

// File: rtl/sap_program_loader.sv
// Parses SYNC/ADDR/COUNT/{HI,LO}xN/CSUM records into consecutive RAM writes; latency: ram_we the cycle after LO.
// Backpressure: in_ready drops only for the single WRITE cycle; held bytes are never dropped.
module sap_program_loader
    import sap_program_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    sap_program_loader_if.slave   ldr
);

    state_t             state_q;
    logic               in_ready_q;
    logic               ram_we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               hold_q;
    logic               done_q;
    logic               err_q;
    logic [7:0]         sum_q;
    logic [7:0]         words_q;
    logic [7:0]         hi_q;

    logic               xfer;
    logic [7:0]         sum_d;
    logic [7:0]         words_d;

    assign xfer    = ldr.in_valid & in_ready_q;
    assign sum_d   = sum_q + ldr.in_data;
    assign words_d = words_q - 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            ram_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sum_q      <= 8'h00;
            words_q    <= 8'h00;
            hi_q       <= 8'h00;
        end else begin
            ram_we_q <= 1'b0;
            unique case (state_q)
                // Outside a record only SYNC matters; it restarts a load even after DONE/ERR.
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (xfer && ldr.in_data == SYNC_BYTE) begin
                        sum_q   <= 8'h00;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        hold_q  <= 1'b1;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (xfer) begin
                        addr_q  <= ldr.in_data[ADDR_W-1:0];
                        sum_q   <= sum_d;
                        state_q <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (xfer) begin
                        words_q <= ldr.in_data;
                        sum_q   <= sum_d;
                        state_q <= (ldr.in_data == 8'h00) ? ST_CSUM : ST_HI;
                    end
                end
                ST_HI: begin
                    if (xfer) begin
                        hi_q    <= ldr.in_data;
                        sum_q   <= sum_d;
                        state_q <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (xfer) begin
                        wdata_q    <= {hi_q, ldr.in_data};
                        sum_q      <= sum_d;
                        words_q    <= words_d;
                        ram_we_q   <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    addr_q     <= addr_q + ADDR_W'(1);
                    in_ready_q <= 1'b1;
                    state_q    <= (words_q == 8'h00) ? ST_CSUM : ST_HI;
                end
                ST_CSUM: begin
                    if (xfer) begin
                        if (sum_ok(sum_q, ldr.in_data)) begin
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ldr.in_ready  = in_ready_q;
    assign ldr.ram_we    = ram_we_q;
    assign ldr.ram_addr  = addr_q;
    assign ldr.ram_wdata = wdata_q;
    assign ldr.cpu_hold  = hold_q;
    assign ldr.load_done = done_q;
    assign ldr.load_err  = err_q;

endmodule

// File: tb/tb_sap_program_loader.sv
// Bench for sap_program_loader: constant vector table, hand-built corner sequences and random records
// checked against a frame-level model of the expected RAM writes and status flags.
module tb_sap_program_loader;
    import sap_program_loader_pkg::*;

    typedef logic [7:0]  bq_t [$];
    typedef logic [23:0] wq_t [$];

    typedef struct {
        string       name;
        logic [95:0] fr;
        int          len;
        logic        done;
        logic        err;
        logic        hold;
        int          nwr;
        logic [71:0] wr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sap_program_loader_if ldr();

    sap_program_loader dut (
        .clk (clk),
        .rst (rst),
        .ldr (ldr)
    );

    always #5 clk = ~clk;

    int   n_chk   = 0;
    int   n_pass  = 0;
    int   bp_viol = 0;
    int   rdy_low = 0;
    bit   mon_en  = 1'b0;
    wq_t  wq;
    vec_t vt [5];

    // Observe the RAM port and the ready/write relationship away from the clock edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (ldr.ram_we === 1'b1) wq.push_back({ldr.ram_addr, ldr.ram_wdata});
            if (ldr.in_ready !== ~ldr.ram_we) bp_viol++;
            if (ldr.in_ready === 1'b0) rdy_low++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit keep_valid);
        bit rdy;
        int t;
        rdy = 1'b0;
        t   = 0;
        ldr.in_data  = b;
        ldr.in_valid = 1'b1;
        while (!rdy && t < 40) begin
            @(negedge clk);
            rdy = (ldr.in_ready === 1'b1);
            @(posedge clk);
            #1;
            t++;
        end
        if (!rdy) begin
            n_chk++;
            $display("FAIL send_timeout: byte 0x%0h not accepted, waited %0d cycles, limit 40", b, t);
        end
        if (!keep_valid) ldr.in_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t fr, input bit b2b);
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i], b2b && (i != fr.size() - 1));
            if (!b2b && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
        end
        ldr.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag, input wq_t exp);
        check({tag, "_nwrites"}, wq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wq.size(); i++)
            check({tag, "_write"}, {8'h00, wq[i]}, {8'h00, exp[i]});
    endtask

    task automatic check_status(input string tag, input logic done, input logic err, input logic hold);
        check({tag, "_done"}, {31'd0, ldr.load_done}, {31'd0, done});
        check({tag, "_err"},  {31'd0, ldr.load_err},  {31'd0, err});
        check({tag, "_hold"}, {31'd0, ldr.cpu_hold},  {31'd0, hold});
    endtask

    task automatic run_vec(input int k);
        bq_t fr;
        wq_t ex;
        for (int i = 0; i < vt[k].len; i++) fr.push_back(vt[k].fr[95 - 8*i -: 8]);
        for (int i = 0; i < vt[k].nwr; i++) ex.push_back(vt[k].wr[71 - 24*i -: 24]);
        wq.delete();
        send_frame(fr, 1'b0);
        check_writes(vt[k].name, ex);
        check_status(vt[k].name, vt[k].done, vt[k].err, vt[k].hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, ldr.in_ready}, 32'd1);
        check({tag, "_ram_we"},   {31'd0, ldr.ram_we},   32'd0);
        check({tag, "_ram_addr"}, {24'd0, ldr.ram_addr}, 32'd0);
        check({tag, "_ram_wdata"},{16'd0, ldr.ram_wdata},32'd0);
        check_status(tag, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bq_t        fr;
        wq_t        ex;
        logic [7:0] a, c, hi, lo, sum, csum, b;
        int         nn;
        logic       exp_done;

        vt[0] = '{"frame1",   96'hA5_0A_03_00_00_02_01_0B_00_E5_00_00, 10, 1'b1, 1'b0, 1'b0, 3, 72'h0A0000_0B0201_0C0B00};
        vt[1] = '{"wrap",     96'hA5_FF_02_12_34_56_78_EB_00_00_00_00,  8, 1'b1, 1'b0, 1'b0, 2, 72'hFF1234_005678_000000};
        vt[2] = '{"badsum",   96'hA5_0A_03_00_00_02_01_0B_00_E4_00_00, 10, 1'b0, 1'b1, 1'b1, 3, 72'h0A0000_0B0201_0C0B00};
        vt[3] = '{"reload",   96'hA5_0A_03_00_00_02_01_0B_00_E5_00_00, 10, 1'b1, 1'b0, 1'b0, 3, 72'h0A0000_0B0201_0C0B00};
        vt[4] = '{"noise",    96'h00_FF_13_A5_20_00_E0_00_00_00_00_00,  7, 1'b1, 1'b0, 1'b0, 0, 72'h0};

        ldr.in_data  = 8'h00;
        ldr.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 5; k++) run_vec(k);

        // in_valid held high across the whole frame: stalls only in the three WRITE cycles.
        wq.delete();
        rdy_low = 0;
        fr = '{8'hA5, 8'h0A, 8'h03, 8'h00, 8'h00, 8'h02, 8'h01, 8'h0B, 8'h00, 8'hE5};
        ex = '{24'h0A0000, 24'h0B0201, 24'h0C0B00};
        send_frame(fr, 1'b1);
        check_writes("bp", ex);
        check("bp_ready_low_cycles", rdy_low, 32'd3);
        check_status("bp", 1'b1, 1'b0, 1'b0);

        // Reset after the second data byte of frame 1.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h0A, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        check_status("inprog", 1'b0, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        wq.delete();
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_writes", wq.size(), 32'd0);
        run_vec(0);

        // Random records: model computes the RAM writes and outcome from the frame rules.
        for (int f = 0; f < 25; f++) begin
            fr.delete();
            ex.delete();
            nn = $urandom_range(0, 2);
            for (int i = 0; i < nn; i++) begin
                b = 8'($urandom);
                if (b == SYNC_BYTE) b = 8'h5A;
                fr.push_back(b);
            end
            a   = 8'($urandom);
            c   = 8'($urandom_range(0, 6));
            fr.push_back(SYNC_BYTE);
            fr.push_back(a);
            fr.push_back(c);
            sum = a + c;
            for (int w = 0; w < int'(c); w++) begin
                hi  = 8'($urandom);
                lo  = 8'($urandom);
                fr.push_back(hi);
                fr.push_back(lo);
                sum = sum + hi + lo;
                ex.push_back({8'(a + 8'(w)), hi, lo});
            end
            csum = 8'h00 - sum;
            if ($urandom_range(0, 3) == 0) csum = csum + 8'($urandom_range(1, 255));
            fr.push_back(csum);
            exp_done = (8'(sum + csum) == 8'h00);

            wq.delete();
            for (int i = 0; i < fr.size(); i++) begin
                send_byte(fr[i], 1'b0);
                if (i == nn + 1) begin
                    check("rand_inprog_done", {31'd0, ldr.load_done}, 32'd0);
                    check("rand_inprog_err",  {31'd0, ldr.load_err},  32'd0);
                end
                if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            repeat (3) @(posedge clk);
            #1;
            check_writes("rand", ex);
            check_status("rand", exp_done, ~exp_done, ~exp_done);
        end

        check("ready_vs_write_violations", bp_viol, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
